// File: rtl/bp_be_pipe_long_idiv_mq.sv
// Queued radix-2 restoring integer divider (DIV/DIVU/REM/REMU and W forms) with tagged valid/yumi writeback.
// Define BP_BE_IDIV_EARLY_EXIT_EN to resolve divide-by-zero, signed overflow and |a|<|b| directly in LOAD.
module bp_be_pipe_long_idiv_mq #(
    parameter int width_p          = 64,
    parameter int word_width_p     = 32,
    parameter int reg_addr_width_p = 5,
    parameter int queue_els_p      = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        flush_i,
    input  logic                        v_i,
    output logic                        ready_o,
    input  logic [1:0]                  fu_op_i,
    input  logic                        opw_v_i,
    input  logic [reg_addr_width_p-1:0] rd_addr_i,
    input  logic [width_p-1:0]          rs1_i,
    input  logic [width_p-1:0]          rs2_i,
    output logic                        v_o,
    input  logic                        yumi_i,
    output logic [reg_addr_width_p-1:0] rd_addr_o,
    output logic [width_p-1:0]          rd_data_o,
    output logic                        busy_o
);

    localparam int ptr_width_lp   = (queue_els_p > 1) ? $clog2(queue_els_p) : 1;
    localparam int count_width_lp = $clog2(queue_els_p + 1);
    localparam int iter_width_lp  = $clog2(width_p + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, FIXUP, DONE} state_e;

    state_e                      state;
    logic [1:0]                  q_op  [queue_els_p];
    logic                        q_w   [queue_els_p];
    logic [reg_addr_width_p-1:0] q_tag [queue_els_p];
    logic [width_p-1:0]          q_a   [queue_els_p];
    logic [width_p-1:0]          q_b   [queue_els_p];
    logic [ptr_width_lp-1:0]     wr_ptr, rd_ptr;
    logic [count_width_lp-1:0]   count;
    logic                        enq, deq;

    logic [1:0]                  head_op;
    logic                        head_w;
    logic [reg_addr_width_p-1:0] head_tag;
    logic [width_p-1:0]          head_a, head_b;
    logic                        is_signed, sign_a, sign_b, b_zero;
    logic [width_p-1:0]          a_ext, b_ext, a_mag, b_mag, dividend;

    logic [width_p-1:0]          rem, quo, div_mag;
    logic [iter_width_lp-1:0]    iter;
    logic                        neg_q, neg_r, rem_op, is_w, div_zero;
    logic [reg_addr_width_p-1:0] tag;

    logic [width_p:0]            shifted;
    logic                        fits;
    logic [width_p-1:0]          rem_next, quo_next;
    logic [width_p-1:0]          q_fix, r_fix, res_raw, result;

    function automatic logic [width_p-1:0] sext_word(input logic [width_p-1:0] x);
        return {{(width_p-word_width_p){x[word_width_p-1]}}, x[word_width_p-1:0]};
    endfunction

    function automatic logic [width_p-1:0] zext_word(input logic [width_p-1:0] x);
        return {{(width_p-word_width_p){1'b0}}, x[word_width_p-1:0]};
    endfunction

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(queue_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (count != count_width_lp'(queue_els_p));
    assign busy_o  = (count != '0) || (state != IDLE);
    assign enq     = v_i && ready_o && !flush_i;
    assign deq     = (state == LOAD) && !flush_i;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            q_op[wr_ptr]  <= fu_op_i;
            q_w[wr_ptr]   <= opw_v_i;
            q_tag[wr_ptr] <= rd_addr_i;
            q_a[wr_ptr]   <= rs1_i;
            q_b[wr_ptr]   <= rs2_i;
        end
    end

    // Operand conditioning for the head entry: W extension, magnitudes, and result signs.
    assign head_op   = q_op[rd_ptr];
    assign head_w    = q_w[rd_ptr];
    assign head_tag  = q_tag[rd_ptr];
    assign head_a    = q_a[rd_ptr];
    assign head_b    = q_b[rd_ptr];
    assign is_signed = ~head_op[0];
    assign a_ext     = head_w ? (is_signed ? sext_word(head_a) : zext_word(head_a)) : head_a;
    assign b_ext     = head_w ? (is_signed ? sext_word(head_b) : zext_word(head_b)) : head_b;
    assign sign_a    = is_signed & a_ext[width_p-1];
    assign sign_b    = is_signed & b_ext[width_p-1];
    assign a_mag     = sign_a ? -a_ext : a_ext;
    assign b_mag     = sign_b ? -b_ext : b_ext;
    assign b_zero    = (b_ext == '0);
    assign dividend  = head_w ? (a_mag << word_width_p) : a_mag;

    // Partial remainder never exceeds the divisor, so the shifted value needs only one extra bit.
    assign shifted  = {rem, quo[width_p-1]};
    assign fits     = (shifted >= {1'b0, div_mag});
    assign rem_next = fits ? (shifted[width_p-1:0] - div_mag) : shifted[width_p-1:0];
    assign quo_next = {quo[width_p-2:0], fits};

    assign q_fix   = div_zero ? '1 : (neg_q ? -quo : quo);
    assign r_fix   = neg_r ? -rem : rem;
    assign res_raw = rem_op ? r_fix : q_fix;
    assign result  = is_w ? sext_word(res_raw) : res_raw;

`ifdef BP_BE_IDIV_EARLY_EXIT_EN
    logic [width_p-1:0] min_val, early_raw, early_res;
    logic               overflow, early_v;

    assign min_val   = head_w ? {{(width_p-word_width_p+1){1'b1}}, {(word_width_p-1){1'b0}}}
                              : {1'b1, {(width_p-1){1'b0}}};
    assign overflow  = is_signed && (a_ext == min_val) && (b_ext == '1);
    assign early_v   = b_zero || overflow || (a_mag < b_mag);
    assign early_raw = head_op[1] ? (overflow ? '0 : a_ext)
                                  : (b_zero ? '1 : (overflow ? a_ext : '0));
    assign early_res = head_w ? sext_word(early_raw) : early_raw;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            div_mag   <= '0;
            iter      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            rem_op    <= 1'b0;
            is_w      <= 1'b0;
            div_zero  <= 1'b0;
            tag       <= '0;
            v_o       <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else if (flush_i) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            v_o    <= 1'b0;
        end else begin
            if (enq) wr_ptr <= next_ptr(wr_ptr);
            if (deq) rd_ptr <= next_ptr(rd_ptr);
            count <= count + count_width_lp'(enq) - count_width_lp'(deq);
            case (state)
                IDLE: if (count != '0) state <= LOAD;
                LOAD: begin
                    rem      <= '0;
                    quo      <= dividend;
                    div_mag  <= b_mag;
                    iter     <= head_w ? iter_width_lp'(word_width_p) : iter_width_lp'(width_p);
                    neg_q    <= sign_a ^ sign_b;
                    neg_r    <= sign_a;
                    rem_op   <= head_op[1];
                    is_w     <= head_w;
                    div_zero <= b_zero;
                    tag      <= head_tag;
`ifdef BP_BE_IDIV_EARLY_EXIT_EN
                    if (early_v) begin
                        rd_data_o <= early_res;
                        rd_addr_o <= head_tag;
                        v_o       <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CALC;
                    end
`else
                    state <= CALC;
`endif
                end
                CALC: begin
                    rem  <= rem_next;
                    quo  <= quo_next;
                    iter <= iter - 1'b1;
                    if (iter == iter_width_lp'(1)) state <= FIXUP;
                end
                FIXUP: begin
                    rd_data_o <= result;
                    rd_addr_o <= tag;
                    v_o       <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (yumi_i) begin
                        v_o   <= 1'b0;
                        state <= (count != '0) ? LOAD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_be_pipe_long_idiv_mq.sv
// Self-checking bench for bp_be_pipe_long_idiv_mq: directed vectors, queue/flush/reset sequences,
// and randomized traffic against an RV64M arithmetic reference model.
module tb_bp_be_pipe_long_idiv_mq;

    localparam int NUM_RAND = 300;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        flush_i;
    logic        v_i;
    logic        ready_o;
    logic [1:0]  fu_op_i;
    logic        opw_v_i;
    logic [4:0]  rd_addr_i;
    logic [63:0] rs1_i;
    logic [63:0] rs2_i;
    logic        v_o;
    logic        yumi_i;
    logic [4:0]  rd_addr_o;
    logic [63:0] rd_data_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  tag;
        logic [63:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    always #5 clk_i = ~clk_i;

    bp_be_pipe_long_idiv_mq dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .fu_op_i   (fu_op_i),
        .opw_v_i   (opw_v_i),
        .rd_addr_i (rd_addr_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .v_o       (v_o),
        .yumi_i    (yumi_i),
        .rd_addr_o (rd_addr_o),
        .rd_data_o (rd_data_o),
        .busy_o    (busy_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV64M semantics from plain integer arithmetic, with the two trap-free corner rules stated explicitly.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q, r, res;
        logic [31:0] a32, b32, tq, tr;
        int          sa32, sb32;
        longint      sa, sb;
        a32 = a[31:0];
        b32 = b[31:0];
        sa32 = a32;
        sb32 = b32;
        sa = a;
        sb = b;
        if (w) begin
            if (b32 == 32'd0) begin
                tq = '1;
                tr = a32;
            end else if (op[0]) begin
                tq = a32 / b32;
                tr = a32 % b32;
            end else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                tq = a32;
                tr = '0;
            end else begin
                tq = sa32 / sb32;
                tr = sa32 % sb32;
            end
            res = op[1] ? {32'd0, tr} : {32'd0, tq};
            res = {{32{res[31]}}, res[31:0]};
        end else begin
            if (b == 64'd0) begin
                q = '1;
                r = a;
            end else if (op[0]) begin
                q = a / b;
                r = a % b;
            end else if (a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
            res = op[1] ? r : q;
        end
        return res;
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
`ifdef BP_BE_IDIV_EARLY_EXIT_EN
        longint      sa, sb;
        logic [63:0] am, bm;
        if (w) begin
            if (op[0]) begin
                sa = longint'({32'd0, a[31:0]});
                sb = longint'({32'd0, b[31:0]});
            end else begin
                sa = longint'({{32{a[31]}}, a[31:0]});
                sb = longint'({{32{b[31]}}, b[31:0]});
            end
        end else begin
            sa = a;
            sb = b;
        end
        am = (!op[0] && sa < 0) ? 64'(-sa) : 64'(sa);
        bm = (!op[0] && sb < 0) ? 64'(-sb) : 64'(sb);
        if (sb == 0) return 2;
        if (!op[0] && sb == -1 && ((w && sa == -64'sd2147483648) || (!w && a == 64'h8000_0000_0000_0000)))
            return 2;
        if (am < bm) return 2;
`endif
        return w ? 35 : 67;
    endfunction

    // Enqueue one op from a mid-cycle and return the latency until v_o, counted in rising edges.
    task automatic applyStimulus(input logic [1:0] op, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] tag,
                                 output logic [63:0] data, output logic [4:0] tag_out, output int lat);
        @(negedge clk_i);
        check("ready_before_issue", 64'(ready_o), 64'd1);
        v_i = 1'b1;
        fu_op_i = op;
        opw_v_i = w;
        rs1_i = a;
        rs2_i = b;
        rd_addr_i = tag;
        @(posedge clk_i);
        #1 v_i = 1'b0;
        lat = 0;
        do begin
            @(posedge clk_i);
            #1;
            lat++;
        end while (!v_o && lat < 300);
        data = rd_data_o;
        tag_out = rd_addr_o;
        yumi_i = v_o;
        @(posedge clk_i);
        #1 yumi_i = 1'b0;
    endtask

    task automatic enqueue(input logic [1:0] op, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag);
        int g;
        @(negedge clk_i);
        v_i = 1'b1;
        fu_op_i = op;
        opw_v_i = w;
        rs1_i = a;
        rs2_i = b;
        rd_addr_i = tag;
        g = 0;
        while (!ready_o && g < 500) begin
            @(negedge clk_i);
            g++;
        end
        if (g >= 500) begin
            failures++;
            $display("FAIL enqueue_timeout: ready_o stuck at %0d, required 1", ready_o);
        end
        @(posedge clk_i);
        #1 v_i = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] tag, input logic [63:0] data);
        int g;
        g = 0;
        @(negedge clk_i);
        while (!v_o && g < 500) begin
            @(negedge clk_i);
            g++;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk_i);
        check({name, "_valid"}, 64'(v_o), 64'd1);
        check({name, "_tag"}, 64'(rd_addr_o), 64'(tag));
        check({name, "_data"}, rd_data_o, data);
        yumi_i = v_o;
        @(posedge clk_i);
        #1 yumi_i = 1'b0;
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: r = 64'd0;
            1: r = '1;
            2: r = 64'h8000_0000_0000_0000;
            3: r = {r[63:32], 32'h8000_0000};
            4: r = 64'($urandom_range(0, 20));
            5: r = r >> $urandom_range(0, 63);
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [63:0] data;
        logic [4:0]  tag_out;
        int          lat;
        int          vo_seen;

        reset_n_i = 1'b0;
        flush_i = 1'b0;
        v_i = 1'b0;
        yumi_i = 1'b0;
        fu_op_i = '0;
        opw_v_i = 1'b0;
        rd_addr_i = '0;
        rs1_i = '0;
        rs2_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        check("reset_ready", 64'(ready_o), 64'd1);
        check("reset_v", 64'(v_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_tag", 64'(rd_addr_o), 64'd0);
        check("reset_data", rd_data_o, 64'd0);

        // op encodings: 00 DIV, 01 DIVU, 10 REM, 11 REMU
        vecs.push_back('{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD});
        vecs.push_back('{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
        vecs.push_back('{2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{2'b01, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{2'b11, 1'b0, 64'd100, 64'd0, 64'd100});
        vecs.push_back('{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
        vecs.push_back('{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
        vecs.push_back('{2'b01, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{2'b11, 1'b1, 64'hFFFF_FFFF_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001});
        vecs.push_back('{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF});
        vecs.push_back('{2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFF6, 64'd0});
        vecs.push_back('{2'b10, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFF6, 64'd3});
        vecs.push_back('{2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{2'b00, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD});
        vecs.push_back('{2'b00, 1'b0, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FF72});
        vecs.push_back('{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 5'(i + 1), data, tag_out, lat);
            check($sformatf("vec%0d_data", i), data, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), 64'(tag_out), 64'(i + 1));
            check($sformatf("vec%0d_latency", i), 64'(lat),
                  64'(exp_latency(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b)));
            check($sformatf("vec%0d_v_after_yumi", i), 64'(v_o), 64'd0);
        end

        // Queue fills after two back-to-back ops; results return in issue order.
        enqueue(2'b00, 1'b0, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 5'd1);
        check("queue_ready_after_1st", 64'(ready_o), 64'd1);
        enqueue(2'b00, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd2);
        check("queue_ready_after_2nd", 64'(ready_o), 64'd0);
        enqueue(2'b11, 1'b0, 64'd12345, 64'd100, 5'd3);
        checkOutput("queue_res1", 5'd1, ref_model(2'b00, 1'b0, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF9));
        checkOutput("queue_res2", 5'd2, ref_model(2'b00, 1'b1, 64'h0000_0000_8000_0000, '1));
        checkOutput("queue_res3", 5'd3, 64'd45);

        // Flush mid-CALC with one op queued and a same-cycle issue that must be dropped.
        enqueue(2'b00, 1'b0, 64'd999_999, 64'd7, 5'd5);
        enqueue(2'b10, 1'b0, 64'd999_999, 64'd7, 5'd6);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        v_i = 1'b1;
        rd_addr_i = 5'd7;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        v_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_ready", 64'(ready_o), 64'd1);
        check("flush_v", 64'(v_o), 64'd0);
        vo_seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_i);
            if (v_o) vo_seen++;
        end
        check("flush_no_result", 64'(vo_seen), 64'd0);
        applyStimulus(2'b01, 1'b0, 64'd1_000_000, 64'd3, 5'd8, data, tag_out, lat);
        check("post_flush_data", data, 64'd333_333);
        check("post_flush_tag", 64'(tag_out), 64'd8);

        // Asynchronous reset mid-CALC clears state and outputs without a clock edge.
        enqueue(2'b00, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'd3, 5'd9);
        repeat (20) @(posedge clk_i);
        #3 reset_n_i = 1'b0;
        #1;
        check("async_reset_v", 64'(v_o), 64'd0);
        check("async_reset_busy", 64'(busy_o), 64'd0);
        check("async_reset_ready", 64'(ready_o), 64'd1);
        check("async_reset_data", rd_data_o, 64'd0);
        check("async_reset_tag", 64'(rd_addr_o), 64'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        applyStimulus(2'b00, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 5'd10, data, tag_out, lat);
        check("post_reset_data", data, 64'hFFFF_FFFF_FFFF_FFF2);
        check("post_reset_latency", 64'(lat), 64'(exp_latency(2'b00, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7)));

        // Randomized traffic with independent issue and writeback stalls.
        fork
            begin
                logic [1:0]  op;
                logic        w;
                logic [63:0] a, b;
                int          budget;
                budget = 0;
                for (int i = 0; i < NUM_RAND; i++) begin
                    op = 2'($urandom_range(0, 3));
                    w = 1'($urandom_range(0, 1));
                    a = rand_operand();
                    b = rand_operand();
                    @(negedge clk_i);
                    v_i = 1'b1;
                    fu_op_i = op;
                    opw_v_i = w;
                    rs1_i = a;
                    rs2_i = b;
                    rd_addr_i = 5'(i);
                    while (!ready_o && budget < 50000) begin
                        @(negedge clk_i);
                        budget++;
                    end
                    if (budget >= 50000) begin
                        v_i = 1'b0;
                        break;
                    end
                    @(posedge clk_i);
                    sb.push_back('{5'(i), ref_model(op, w, a, b)});
                    #1 v_i = 1'b0;
                    repeat ($urandom_range(0, 3)) @(posedge clk_i);
                end
            end
            begin
                sb_t e;
                int  got, cyc;
                got = 0;
                cyc = 0;
                while (got < NUM_RAND && cyc < 60000) begin
                    @(negedge clk_i);
                    cyc++;
                    yumi_i = 1'b0;
                    if (v_o && $urandom_range(0, 3) != 0) begin
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL rand_spurious: v_o=1 tag %0d with no outstanding op", rd_addr_o);
                        end else begin
                            e = sb.pop_front();
                            check("rand_tag", 64'(rd_addr_o), 64'(e.tag));
                            check("rand_data", rd_data_o, e.data);
                        end
                        yumi_i = 1'b1;
                        got++;
                    end
                end
                @(negedge clk_i);
                yumi_i = 1'b0;
                check("rand_completed", 64'(got), 64'(NUM_RAND));
            end
        join

        repeat (5) @(negedge clk_i);
        check("final_idle", 64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
